// File: rtl/ex_co_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_co_arbiter_pkg
//  Brief    : Shared execute/complete definitions: FU type enum, FU counts,
//             EX/CO packet layout.
//  Revision : 1.0 - initial release
// ============================================================================
package ex_co_arbiter_pkg;

  // Functional-unit kinds; the value travels in the packet as function_type.
  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_MULT   = 3'd1,
    FU_BRANCH = 3'd2,
    FU_LOAD   = 3'd3,
    FU_STORE  = 3'd4
  } fu_type_e;

  localparam int NUM_FU_ALU    = 1;
  localparam int NUM_FU_MULT   = 1;
  localparam int NUM_FU_BRANCH = 1;
  localparam int NUM_FU_LOAD   = 1;
  localparam int NUM_FU_STORE  = 1;

  // One result port per FU instance.
  localparam int N_IN_DEFAULT = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_BRANCH
                              + NUM_FU_LOAD + NUM_FU_STORE;

  localparam int ROB_IDX_W = 6;

  // Result packet handed from an FU to the complete stage.
  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_index;
    logic [2:0]           issued_fu_index;
    fu_type_e             function_type;
    logic [31:0]          result;
  } ex_co_packet_t;

endpackage
`default_nettype wire

// File: rtl/ex_co_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_co_arbiter_if
//  Brief    : FU-result / EX-CO handshake bundle. master = FUs + complete
//             stage side, slave = arbiter side.
//  Revision : 1.0 - initial release
// ============================================================================
interface ex_co_arbiter_if #(
  parameter int N_IN  = ex_co_arbiter_pkg::N_IN_DEFAULT,
  parameter int PTR_W = $clog2(N_IN)   // derived; leave at default
) ();
  import ex_co_arbiter_pkg::*;

  logic          [N_IN-1:0]  fu_valid;
  ex_co_packet_t [N_IN-1:0]  fu_packet;
  logic          [N_IN-1:0]  fu_ready;
  logic                      out_ready;
  ex_co_packet_t             ex_co_reg;
  logic          [PTR_W-1:0] grant_idx;

  modport master (
    output fu_valid, fu_packet, out_ready,
    input  fu_ready, ex_co_reg, grant_idx
  );

  modport slave (
    input  fu_valid, fu_packet, out_ready,
    output fu_ready, ex_co_reg, grant_idx
  );

endinterface
`default_nettype wire

// File: rtl/ex_co_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin picker. Scans req starting at ptr,
//             wrapping modulo N; the first set bit wins (one-hot gnt).
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = ex_co_arbiter_pkg::N_IN_DEFAULT,
  parameter int PTR_W = $clog2(N)   // derived; leave at default
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any_gnt
);
  import ex_co_arbiter_pkg::*;

  logic [PTR_W-1:0] cand;

  // Walk the request vector from ptr upward with wrap; stop at first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N);
      if (!any_gnt && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        any_gnt   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_co_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ex_co_arbiter
//  Brief    : Buffers one result per FU (valid/ready) and serialises them
//             round-robin into the registered EX/CO packet, one per cycle.
//  Options  : EX_CO_ARB_BRANCH_PRIO_EN - buffered BRANCH results win over
//             round-robin (lowest index first, pointer left untouched).
//  Revision : 1.0 - initial release
// ============================================================================
module ex_co_arbiter #(
  parameter int N_IN  = ex_co_arbiter_pkg::N_IN_DEFAULT,
  parameter int PTR_W = $clog2(N_IN)   // derived; leave at default
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash,
  ex_co_arbiter_if.slave  bus
);
  import ex_co_arbiter_pkg::*;

  logic          [N_IN-1:0]  buf_valid_q, buf_valid_d;
  ex_co_packet_t [N_IN-1:0]  buf_q, buf_d;
  logic          [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  ex_co_packet_t             ex_co_reg_q, ex_co_reg_d;

  logic             out_free;
  logic             arb_en;
  logic [N_IN-1:0]  req_vec;
  logic [N_IN-1:0]  rr_gnt;
  logic [PTR_W-1:0] rr_idx;
  logic             rr_any;
  logic [N_IN-1:0]  grant;
  logic [PTR_W-1:0] grant_idx;
  logic             any_grant;
  logic             prio_grant;
  logic [N_IN-1:0]  fu_ready;

  // The output slot is reusable when empty or being consumed this edge;
  // a squash suppresses arbitration entirely.
  assign out_free = !ex_co_reg_q.valid || bus.out_ready;
  assign arb_en   = out_free && !squash;
  assign req_vec  = buf_valid_q & {N_IN{arb_en}};

  rr_arbiter #(.N(N_IN), .PTR_W(PTR_W)) u_rr_arbiter (
    .req     (req_vec),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any_gnt (rr_any)
  );

`ifdef EX_CO_ARB_BRANCH_PRIO_EN
  // Branch results jump the queue so mispredicts resolve sooner.
  always_comb begin
    grant      = rr_gnt;
    grant_idx  = rr_idx;
    prio_grant = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (!prio_grant && req_vec[i] && (buf_q[i].function_type == FU_BRANCH)) begin
        prio_grant   = 1'b1;
        grant        = '0;
        grant[i]     = 1'b1;
        grant_idx    = PTR_W'(i);
      end
    end
    any_grant = prio_grant || rr_any;
  end
`else
  assign grant      = rr_gnt;
  assign grant_idx  = rr_idx;
  assign any_grant  = rr_any;
  assign prio_grant = 1'b0;
`endif

  // A buffer can take a new packet if empty or if it is draining this cycle.
  assign fu_ready = {N_IN{!reset}} & (~buf_valid_q | grant);

  // Next-state for buffers, output register and round-robin pointer.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    rr_ptr_d    = rr_ptr_q;
    ex_co_reg_d = ex_co_reg_q;
    if (squash) begin
      // Flush everything in flight, including a same-cycle FU handshake.
      buf_valid_d       = '0;
      ex_co_reg_d.valid = 1'b0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (grant[i]) begin
          buf_valid_d[i] = 1'b0;
        end
        // Refill overrides the clear so a port sustains one packet per cycle.
        if (bus.fu_valid[i] && fu_ready[i]) begin
          buf_d[i]       = bus.fu_packet[i];
          buf_valid_d[i] = 1'b1;
        end
      end
      if (any_grant) begin
        ex_co_reg_d       = buf_q[grant_idx];
        ex_co_reg_d.valid = 1'b1;
        if (!prio_grant) begin
          rr_ptr_d = (grant_idx == PTR_W'(N_IN - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
      end else if (out_free) begin
        ex_co_reg_d.valid = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid_q <= '0;
      buf_q       <= '0;
      rr_ptr_q    <= '0;
      ex_co_reg_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      rr_ptr_q    <= rr_ptr_d;
      ex_co_reg_q <= ex_co_reg_d;
    end
  end

  assign bus.fu_ready  = fu_ready;
  assign bus.ex_co_reg = ex_co_reg_q;
  assign bus.grant_idx = grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_ex_co_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_co_arbiter
//  Brief    : Directed self-checking bench for ex_co_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_co_arbiter;
  import ex_co_arbiter_pkg::*;

  localparam int N = 5;

  logic clock = 1'b0;
  logic reset;
  logic squash;

  always #5 clock = ~clock;

  ex_co_arbiter_if #(.N_IN(N)) bus ();

  ex_co_arbiter #(.N_IN(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_co_packet_t mk(input logic [5:0] rob, input logic [2:0] fu, input fu_type_e ft);
    ex_co_packet_t p;
    p                 = '0;
    p.rob_index       = rob;
    p.issued_fu_index = fu;
    p.function_type   = ft;
    p.result          = {26'd0, rob} + 32'h100;
    return p;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input int p, input logic [5:0] rob, input fu_type_e ft);
    bus.fu_valid[p]  = 1'b1;
    bus.fu_packet[p] = mk(rob, 3'(p), ft);
  endtask

  task automatic rst_pulse();
    reset        = 1'b1;
    bus.fu_valid = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset with all FUs offering ----------------
    reset         = 1'b1;
    squash        = 1'b0;
    bus.out_ready = 1'b1;
    bus.fu_valid  = '0;
    bus.fu_packet = '0;
    for (int i = 0; i < N; i++) offer(i, 6'(10 + i), FU_ALU);
    #1;
    chk("rst_ready_pre", bus.fu_ready, 5'b00000);
    repeat (2) begin
      step();
      chk("rst_valid", bus.ex_co_reg.valid, 1'b0);
      chk("rst_ready", bus.fu_ready, 5'b00000);
    end
    reset        = 1'b0;
    bus.fu_valid = '0;
    #1;
    chk("post_rst_ready", bus.fu_ready, 5'b11111);
    step();
    chk("post_rst_valid", bus.ex_co_reg.valid, 1'b0);

    // ---------------- single packet on port 2 ----------------
    offer(2, 6'd7, FU_ALU);
    step();
    bus.fu_valid = '0;
    #1;
    chk("single_nobypass", bus.ex_co_reg.valid, 1'b0);
    chk("single_gidx", bus.grant_idx, 3'd2);
    step();
    chk("single_valid", bus.ex_co_reg.valid, 1'b1);
    chk("single_rob", bus.ex_co_reg.rob_index, 6'd7);
    chk("single_fu", bus.ex_co_reg.issued_fu_index, 3'd2);
    chk("single_res", bus.ex_co_reg.result, 32'h107);
    step();
    chk("single_drain", bus.ex_co_reg.valid, 1'b0);

    // ---------------- contention from rr_ptr = 0 ----------------
    rst_pulse();
    for (int i = 0; i < N; i++) offer(i, 6'(20 + i), FU_ALU);
    step();
    bus.fu_valid = '0;
    #1;
    chk("cont_gidx0", bus.grant_idx, 3'd0);
    for (int k = 0; k < N; k++) begin
      step();
      chk("cont_valid", bus.ex_co_reg.valid, 1'b1);
      chk("cont_rob", bus.ex_co_reg.rob_index, 6'(20 + k));
    end
    step();
    chk("cont_empty", bus.ex_co_reg.valid, 1'b0);
    offer(1, 6'd31, FU_ALU);
    offer(3, 6'd33, FU_ALU);
    step();
    bus.fu_valid = '0;
    step();
    chk("wrap_first", bus.ex_co_reg.rob_index, 6'd31);
    step();
    chk("wrap_second", bus.ex_co_reg.rob_index, 6'd33);
    step();
    chk("wrap_empty", bus.ex_co_reg.valid, 1'b0);

    // ---------------- backpressure (rr_ptr = 4) ----------------
    offer(0, 6'd40, FU_ALU);
    offer(1, 6'd41, FU_ALU);
    offer(2, 6'd42, FU_ALU);
    step();
    bus.fu_valid = '0;
    step();
    chk("bp_first", bus.ex_co_reg.rob_index, 6'd40);
    bus.out_ready = 1'b0;
    #1;
    chk("bp_ready", bus.fu_ready, 5'b11001);
    repeat (3) begin
      step();
      chk("bp_hold_valid", bus.ex_co_reg.valid, 1'b1);
      chk("bp_hold_rob", bus.ex_co_reg.rob_index, 6'd40);
      chk("bp_hold_ready", bus.fu_ready, 5'b11001);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_drain1", bus.ex_co_reg.rob_index, 6'd41);
    step();
    chk("bp_drain2", bus.ex_co_reg.rob_index, 6'd42);
    step();
    chk("bp_empty", bus.ex_co_reg.valid, 1'b0);

    // ---------------- squash (rr_ptr = 3) ----------------
    offer(1, 6'd51, FU_ALU);
    step();
    bus.fu_valid = '0;
    offer(0, 6'd50, FU_ALU);
    offer(2, 6'd52, FU_ALU);
    step();
    bus.fu_valid = '0;
    chk("sq_pre_rob", bus.ex_co_reg.rob_index, 6'd51);
    squash = 1'b1;
    offer(4, 6'd54, FU_ALU);
    #1;
    chk("sq_ready", bus.fu_ready, 5'b11010);
    step();
    squash       = 1'b0;
    bus.fu_valid = '0;
    #1;
    chk("sq_valid", bus.ex_co_reg.valid, 1'b0);
    chk("sq_empty", bus.fu_ready, 5'b11111);
    repeat (3) begin
      step();
      chk("sq_nothing", bus.ex_co_reg.valid, 1'b0);
    end

    // ---------------- refill on the granted port (rr_ptr = 2) ----------------
    offer(2, 6'd56, FU_ALU);
    step();
    offer(2, 6'd57, FU_ALU);
    #1;
    chk("refill_ready", bus.fu_ready[2], 1'b1);
    chk("refill_gidx", bus.grant_idx, 3'd2);
    step();
    bus.fu_valid = '0;
    chk("refill_old", bus.ex_co_reg.rob_index, 6'd56);
    step();
    chk("refill_new", bus.ex_co_reg.rob_index, 6'd57);
    chk("refill_new_v", bus.ex_co_reg.valid, 1'b1);
    step();
    chk("refill_empty", bus.ex_co_reg.valid, 1'b0);

    // ---------------- branch priority (rr_ptr = 0) ----------------
    rst_pulse();
    offer(0, 6'd60, FU_ALU);
    offer(3, 6'd63, FU_BRANCH);
    step();
    bus.fu_valid = '0;
    step();
`ifdef EX_CO_ARB_BRANCH_PRIO_EN
    chk("br_first", bus.ex_co_reg.rob_index, 6'd63);
    step();
    chk("br_second", bus.ex_co_reg.rob_index, 6'd60);
`else
    chk("br_first", bus.ex_co_reg.rob_index, 6'd60);
    step();
    chk("br_second", bus.ex_co_reg.rob_index, 6'd63);
`endif
    step();
    chk("br_empty", bus.ex_co_reg.valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
